// File: rtl/cs_intra_recon_pkg.sv
// cs_intra_recon_pkg: shared sizes, sampling/predictor encodings and FSM states for intra reconstruction
package cs_intra_recon_pkg;
    localparam int CS_DATA_WIDTH = 16;
    localparam int CS_LANES      = 16;
    localparam int CS_MAX_CYCLES = 8;
    typedef enum logic [1:0] {SMP_FULL = 2'b00, SMP_HALF = 2'b01, SMP_QUARTER = 2'b10, SMP_RSVD = 2'b11} smp_e;
    typedef enum logic [1:0] {PM_LEFT = 2'b00, PM_UP = 2'b01, PM_DC = 2'b10, PM_ZERO = 2'b11} pmode_e;
    typedef enum logic [1:0] {ST_IDLE, ST_RECON, ST_DONE} state_e;
    // Reserved sampling mode runs as full sampling.
    function automatic int last_cycle(input logic [1:0] smp, input int max_cycles);
        return smp == SMP_HALF ? max_cycles / 2 - 1 : smp == SMP_QUARTER ? max_cycles / 4 - 1 : max_cycles - 1;
    endfunction
endpackage

// File: rtl/cs_recon_lane.sv
// cs_recon_lane: one residual + predictor adder; CS_RECON_SAT_EN clamps signed residual + unsigned predictor
module cs_recon_lane #(
    parameter int DATA_WIDTH = 16
) (
    input  logic [DATA_WIDTH-1:0] residual,
    input  logic [DATA_WIDTH-1:0] pred,
    output logic [DATA_WIDTH-1:0] y
);
`ifdef CS_RECON_SAT_EN
    logic signed [DATA_WIDTH+1:0] s;
    assign s = $signed({2'b00, pred}) + $signed({{2{residual[DATA_WIDTH-1]}}, residual});
    assign y = s[DATA_WIDTH+1] ? '0 : s[DATA_WIDTH] ? '1 : s[DATA_WIDTH-1:0];
`else
    assign y = residual + pred;
`endif
endmodule

// File: rtl/cs_intra_recon.sv
// cs_intra_recon: rebuilds y = residual + predictor, LANES samples per cycle over 8/4/2 cycles
// CS_RECON_SAT_EN switches every lane from modulo wrap to clamped signed-residual addition
module cs_intra_recon
    import cs_intra_recon_pkg::*;
#(
    parameter int DATA_WIDTH = CS_DATA_WIDTH,
    parameter int LANES      = CS_LANES,
    parameter int MAX_CYCLES = CS_MAX_CYCLES,
    localparam int PACKET_LEN = DATA_WIDTH * LANES * MAX_CYCLES,
    localparam int CW         = $clog2(MAX_CYCLES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            sampling_mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PACKET_LEN-1:0] y_residual,
    input  logic [1:0]            predicted_mode,
    input  logic [DATA_WIDTH-1:0] y_p_left_cand_0,
    input  logic [DATA_WIDTH-1:0] y_p_up_cand_0,
    input  logic [DATA_WIDTH-1:0] y_p_dc_cand_0,
    input  logic [DATA_WIDTH-1:0] y_p_left_cand,
    input  logic [DATA_WIDTH-1:0] y_p_up_cand,
    input  logic [DATA_WIDTH-1:0] y_p_dc_cand,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PACKET_LEN-1:0] y_recon,
    output logic                  recon_busy,
    output logic                  mode_err
);
    state_e                state, state_nx;
    logic [CW-1:0]         cnt, last_q;
    logic [PACKET_LEN-1:0] res_q;
    logic [DATA_WIDTH-1:0] pred0_q, pred_q, pred0_sel, pred_sel;
    logic [DATA_WIDTH-1:0] lane_res [LANES];
    logic [DATA_WIDTH-1:0] lane_pred [LANES];
    logic [DATA_WIDTH-1:0] lane_y [LANES];
    logic                  accept;

    assign in_ready   = rst && state == ST_IDLE;
    assign accept     = in_valid && in_ready;
    assign out_valid  = state == ST_DONE;
    assign recon_busy = state == ST_RECON;
    assign pred0_sel  = predicted_mode == PM_LEFT ? y_p_left_cand_0 :
                        predicted_mode == PM_UP   ? y_p_up_cand_0   :
                        predicted_mode == PM_DC   ? y_p_dc_cand_0   : '0;
    assign pred_sel   = predicted_mode == PM_LEFT ? y_p_left_cand :
                        predicted_mode == PM_UP   ? y_p_up_cand   :
                        predicted_mode == PM_DC   ? y_p_dc_cand   : '0;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= ST_IDLE;
        else      state <= state_nx;

    always_comb begin
        state_nx = state;
        if (state == ST_IDLE && accept) state_nx = ST_RECON;
        if (state == ST_RECON && cnt == last_q) state_nx = ST_DONE;
        if (state == ST_DONE && out_ready) state_nx = ST_IDLE;
    end

    // Lane l handles sample cnt + MAX_CYCLES*l; only sample 0 uses the dedicated predictor.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_res[l]  = res_q[DATA_WIDTH*(int'(cnt) + MAX_CYCLES*l) +: DATA_WIDTH];
        assign lane_pred[l] = (l == 0 && cnt == '0) ? pred0_q : pred_q;
        cs_recon_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .residual (lane_res[l]),
            .pred     (lane_pred[l]),
            .y        (lane_y[l])
        );
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt      <= '0;
            last_q   <= '0;
            res_q    <= '0;
            pred0_q  <= '0;
            pred_q   <= '0;
            y_recon  <= '0;
            mode_err <= 1'b0;
        end else if (accept) begin
            cnt      <= '0;
            last_q   <= CW'(last_cycle(sampling_mode, MAX_CYCLES));
            res_q    <= y_residual;
            pred0_q  <= pred0_sel;
            pred_q   <= pred_sel;
            y_recon  <= '0;
            mode_err <= sampling_mode == SMP_RSVD;
        end else if (state == ST_RECON) begin
            cnt <= cnt + 1'b1;
            for (int l = 0; l < LANES; l++)
                y_recon[DATA_WIDTH*(int'(cnt) + MAX_CYCLES*l) +: DATA_WIDTH] <= lane_y[l];
        end
endmodule

// File: tb/tb_cs_intra_recon.sv
// tb_cs_intra_recon: directed vectors with a scoreboard queue checked by an output monitor
module tb_cs_intra_recon;
    localparam int NS = 128;
    typedef logic [2047:0] pkt_t;
    typedef struct {
        pkt_t recon;
        logic err;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b0;
    logic [1:0]  sampling_mode = 2'b00, predicted_mode = 2'b00;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    pkt_t        y_residual = '0;
    logic [15:0] left0 = 0, left = 0, up0 = 0, up = 0, dc0 = 0, dc = 0;
    logic        in_ready, out_valid, recon_busy, mode_err;
    pkt_t        y_recon;
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0, errors = 0;
    pkt_t        res, snap;

`ifdef CS_RECON_SAT_EN
    localparam logic [15:0] T3_S0 = 16'h0000, T3_S1 = 16'hFFFF;
`else
    localparam logic [15:0] T3_S0 = 16'hFFF5, T3_S1 = 16'h7FEF;
`endif

    cs_intra_recon dut (
        .clk(clk), .rst(rst), .sampling_mode(sampling_mode), .in_valid(in_valid), .in_ready(in_ready),
        .y_residual(y_residual), .predicted_mode(predicted_mode),
        .y_p_left_cand_0(left0), .y_p_up_cand_0(up0), .y_p_dc_cand_0(dc0),
        .y_p_left_cand(left), .y_p_up_cand(up), .y_p_dc_cand(dc),
        .out_valid(out_valid), .out_ready(out_ready), .y_recon(y_recon),
        .recon_busy(recon_busy), .mode_err(mode_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] smp(input pkt_t p, input int k);
        return p[16*k +: 16];
    endfunction

    function automatic logic [15:0] add(input logic [15:0] a, input logic [15:0] b);
`ifdef CS_RECON_SAT_EN
        int s = int'($signed(a)) + int'(b);
        return s < 0 ? 16'h0000 : s > 65535 ? 16'hFFFF : 16'(s);
`else
        return a + b;
`endif
    endfunction

    // Expected packet: slot c = k % 8 is filled only for c < n.
    function automatic pkt_t model(input pkt_t r, input logic [15:0] p0, input logic [15:0] p, input int n);
        pkt_t o = '0;
        for (int k = 0; k < NS; k++)
            if (k % 8 < n) o[16*k +: 16] = add(r[16*k +: 16], k == 0 ? p0 : p);
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic chk_pkt(input string nm, input pkt_t act, input pkt_t req);
        checks++;
        if (act !== req) begin
            errors++;
            for (int k = 0; k < NS; k++)
                if (smp(act, k) !== smp(req, k)) begin
                    $display("FAIL %s sample %0d got %0h want %0h", nm, k, smp(act, k), smp(req, k));
                    break;
                end
        end
    endtask

    always @(negedge clk)
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_output");
            end else begin
                mon_e = exp_q.pop_front();
                chk_pkt("sb_recon", y_recon, mon_e.recon);
                chk("sb_mode_err", {31'b0, mode_err}, {31'b0, mon_e.err});
            end
        end

    // Drive one packet, push its expectation at the accept edge, then scramble inputs.
    task automatic issue(input logic [1:0] sm, input logic [1:0] md, input pkt_t r, input pkt_t er, input logic ee);
        int w = 0;
        @(negedge clk);
        sampling_mode = sm;
        predicted_mode = md;
        y_residual = r;
        in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("in_ready_at_issue", {31'b0, in_ready}, 1);
        @(posedge clk);
        exp_q.push_back('{er, ee});
        #1;
        in_valid = 1'b0;
        y_residual = ~r;
        sampling_mode = ~sm;
        predicted_mode = ~md;
        {left0, left, up0, up, dc0, dc} = ~{left0, left, up0, up, dc0, dc};
    endtask

    task automatic wait_done(input string nm, input int n);
        int lat = 0;
        chk({nm, "_busy"}, {31'b0, recon_busy}, 1);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, n);
    endtask

    task automatic finish_pkt(input string nm);
        @(posedge clk);
        #1;
        chk({nm, "_valid_drop"}, {31'b0, out_valid}, 0);
        chk({nm, "_ready_back"}, {31'b0, in_ready}, 1);
    endtask

    initial begin
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 0);
        chk("rst_out_valid", {31'b0, out_valid}, 0);
        chk("rst_busy", {31'b0, recon_busy}, 0);
        chk("rst_mode_err", {31'b0, mode_err}, 0);
        chk_pkt("rst_recon", y_recon, '0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", {31'b0, in_ready}, 1);

        // Left predictor, full sampling
        res = '0;
        for (int k = 0; k < NS; k++) res[16*k +: 16] = 16'd5;
        res[15:0] = 16'd3;
        {left0, left, up0, up, dc0, dc} = {16'd100, 16'd50, 16'd11, 16'd12, 16'd13, 16'd14};
        issue(2'b00, 2'b00, res, model(res, 16'd100, 16'd50, 8), 1'b0);
        wait_done("t1", 8);
        chk("t1_s0", smp(y_recon, 0), 103);
        chk("t1_s127", smp(y_recon, 127), 55);
        finish_pkt("t1");

        // Zero predictor, quarter sampling
        for (int k = 0; k < NS; k++) res[16*k +: 16] = 16'(k);
        {left0, left, up0, up, dc0, dc} = {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
        issue(2'b10, 2'b11, res, model(res, 16'd0, 16'd0, 2), 1'b0);
        wait_done("t2", 2);
        chk("t2_s1", smp(y_recon, 1), 1);
        chk("t2_s8", smp(y_recon, 8), 8);
        chk("t2_s121", smp(y_recon, 121), 121);
        chk("t2_s2_unused", smp(y_recon, 2), 0);
        chk("t2_s127_unused", smp(y_recon, 127), 0);
        finish_pkt("t2");

        // DC predictor with wrap / clamp corner values
        res = '0;
        res[15:0] = 16'hFFF0;
        res[31:16] = 16'h7FFF;
        {left0, left, up0, up, dc0, dc} = {16'd9, 16'd9, 16'd9, 16'd9, 16'd5, 16'hFFF0};
        issue(2'b00, 2'b10, res, model(res, 16'd5, 16'hFFF0, 8), 1'b0);
        wait_done("t3", 8);
        chk("t3_s0", smp(y_recon, 0), T3_S0);
        chk("t3_s1", smp(y_recon, 1), T3_S1);
        chk("t3_s2", smp(y_recon, 2), 16'hFFF0);
        finish_pkt("t3");

        // Back-pressure in DONE, half sampling, up predictor
        for (int k = 0; k < NS; k++) res[16*k +: 16] = 16'(k * 7 + 1);
        {left0, left, up0, up, dc0, dc} = {16'd1, 16'd1, 16'd200, 16'd300, 16'd1, 16'd1};
        out_ready = 1'b0;
        issue(2'b01, 2'b01, res, model(res, 16'd200, 16'd300, 4), 1'b0);
        wait_done("t4", 4);
        chk("t4_s0", smp(y_recon, 0), 201);
        chk("t4_s4_unused", smp(y_recon, 4), 0);
        snap = y_recon;
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("t4_hold_valid", {31'b0, out_valid}, 1);
            chk("t4_hold_in_ready", {31'b0, in_ready}, 0);
            chk_pkt("t4_hold_recon", y_recon, snap);
        end
        out_ready = 1'b1;
        finish_pkt("t4");

        // Reset in the middle of RECON
        {left0, left, up0, up, dc0, dc} = {16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60};
        issue(2'b00, 2'b00, res, model(res, 16'd10, 16'd20, 8), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5_busy_before", {31'b0, recon_busy}, 1);
        #1 rst = 1'b0;
        #1;
        chk("t5_busy", {31'b0, recon_busy}, 0);
        chk("t5_out_valid", {31'b0, out_valid}, 0);
        chk("t5_in_ready", {31'b0, in_ready}, 0);
        chk_pkt("t5_recon", y_recon, '0);
        exp_q.delete();
        @(negedge clk) rst = 1'b1;
        @(posedge clk);
        #1;
        chk("t5_ready_after", {31'b0, in_ready}, 1);
        for (int k = 0; k < NS; k++) res[16*k +: 16] = 16'(k);
        {left0, left, up0, up, dc0, dc} = {16'd1, 16'd2, 16'd3, 16'd4, 16'd1000, 16'd2000};
        issue(2'b00, 2'b10, res, model(res, 16'd1000, 16'd2000, 8), 1'b0);
        wait_done("t5b", 8);
        chk("t5b_s0", smp(y_recon, 0), 1000);
        chk("t5b_s5", smp(y_recon, 5), 2005);
        finish_pkt("t5b");

        // Reserved sampling mode runs full length and flags mode_err
        for (int k = 0; k < NS; k++) res[16*k +: 16] = 16'(3 * k);
        {left0, left, up0, up, dc0, dc} = {16'd100, 16'd100, 16'd7, 16'd9, 16'd100, 16'd100};
        issue(2'b11, 2'b01, res, model(res, 16'd7, 16'd9, 8), 1'b1);
        wait_done("t6", 8);
        chk("t6_mode_err", {31'b0, mode_err}, 1);
        chk("t6_s0", smp(y_recon, 0), 7);
        chk("t6_s127", smp(y_recon, 127), 390);
        finish_pkt("t6");
        chk("t6_mode_err_cleared_next", {31'b0, in_ready}, 1);

        repeat (2) @(posedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
